bmem_line_adapter: RTL
======================

BMEM_LINE_ADAPTER -- requirements
Module: bmem_line_adapter

Interface
REQ-001 SHALL have parameter LINE_W, default 256, meaning cache-line width in bits.
REQ-002 SHALL have parameter BEAT_W, default 64, meaning bmem data beat width in bits; beats per line NBEAT = LINE_W/BEAT_W = 4.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset (rst=0 resets immediately, independent of clk).
REQ-005 SHALL have port dfp_addr  input  32  line request address from cache.
REQ-006 SHALL have port dfp_read  input  1  line read request, held by cache until dfp_resp.
REQ-007 SHALL have port dfp_write  input  1  line write request, held by cache until dfp_resp.
REQ-008 SHALL have port dfp_wdata  input  LINE_W  line write data.
REQ-009 SHALL have port dfp_rdata  output  LINE_W  assembled read line, valid while dfp_resp=1.
REQ-010 SHALL have port dfp_resp  output  1  one-cycle completion pulse for read or write.
REQ-011 SHALL have ports bmem_addr output 32, bmem_read output 1, bmem_write output 1, bmem_wdata output BEAT_W: request side of banked memory.
REQ-012 SHALL have ports bmem_ready input 1, bmem_raddr input 32, bmem_rdata input BEAT_W, bmem_rvalid input 1: response side of banked memory.
REQ-013 SHALL have port err  output  1  sticky protocol-error flag.

Function
REQ-014 SHALL implement FSM states IDLE, RD_REQ, RD_WAIT, WR_BURST, RESP.
REQ-015 IDLE: on dfp_read=1 SHALL latch line address {dfp_addr[31:5],5'b0} and go RD_REQ; else on dfp_write=1 SHALL latch address and dfp_wdata and go WR_BURST; read wins if both asserted.
REQ-016 dfp_read/dfp_write SHALL be ignored in every state other than IDLE.
REQ-017 RD_REQ: SHALL drive bmem_read=1, bmem_addr=latched line address; on bmem_ready=1 go RD_WAIT, else hold request unchanged.
REQ-018 RD_WAIT: beat accepted when bmem_rvalid=1 and bmem_raddr equals latched line address; beat k (k=0..3, arrival order) SHALL be stored in line bits [64k+63:64k].
REQ-019 Beat counter SHALL be 2 bits; acceptance of beat 3 SHALL move to RESP on the next edge (no wrap to beat 0 within a burst).
REQ-020 WR_BURST: SHALL drive bmem_write=1, bmem_addr=latched address, bmem_wdata=latched line bits [64k+63:64k] for beat counter k; k advances only on cycles with bmem_ready=1; beat 3 accepted -> RESP.
REQ-021 RESP: SHALL drive dfp_resp=1 for exactly one cycle, dfp_rdata=assembled line (for writes, dfp_rdata content is don't-care but stable); then IDLE.
REQ-022 bmem_read and bmem_write SHALL never be asserted in the same cycle; both SHALL be 0 in IDLE, RD_WAIT, RESP.
REQ-023 Read latency: minimum 1 (RD_REQ) + 4 beats + 1 (RESP) cycles after dfp_read sampled in IDLE, given ready and back-to-back rvalid.
REQ-024 Write latency: minimum 4 cycles WR_BURST + 1 cycle RESP after dfp_write sampled in IDLE.
REQ-025 bmem_rvalid=1 with raddr mismatch, or bmem_rvalid=1 outside RD_WAIT, SHALL discard the beat and set err=1; err remains 1 until reset.
REQ-026 Non-consecutive rvalid beats (gaps) SHALL be tolerated; counter holds during gaps.

Reset
REQ-027 While rst=0: state=IDLE, beat counter=0, dfp_resp=0, bmem_read=0, bmem_write=0, bmem_addr=0, bmem_wdata=0, dfp_rdata=0, err=0.
REQ-028 Reset asserted mid-burst SHALL abandon the transaction; beats arriving after release with no read outstanding SHALL set err per REQ-025.
REQ-029 First request after release SHALL be sampled on the first rising edge with rst=1.

Verification
REQ-030 Read 0x0000_1040, ready=1, beats 0x11..,0x22..,0x33..,0x44.. back-to-back with raddr 0x0000_1040 -> bmem_addr=0x0000_1040 one cycle, dfp_resp 6 cycles after request, dfp_rdata={beat3,beat2,beat1,beat0}, err=0.
REQ-031 Write 0x0000_2000 line 0x..04_..03_..02_..01, bmem_ready low on cycle 2 of burst -> bmem_wdata sequence 01,02,02,03,04 with write held 5 cycles, single dfp_resp.
REQ-032 dfp_read and dfp_write both 1 in IDLE -> read burst issued, no bmem_write asserted before dfp_resp.
REQ-033 rvalid with raddr 0x0000_3000 during read of 0x0000_1040 -> beat dropped, err=1, correct line still assembled from matching beats.
REQ-034 rst=0 asserted after beat 1 of read -> outputs at reset values asynchronously; remaining 2 beats after release -> err=1, no dfp_resp.
REQ-035 Read beats with 3-cycle gaps between each rvalid -> identical dfp_rdata to REQ-030, dfp_resp one cycle after last beat.

Source files
------------

// File: rtl/bmem_line_adapter.sv
// bmem_line_adapter
// Converts whole-line read/write requests from a cache into NBEAT-beat bursts
// on a banked memory. Reads are reassembled from tagged return beats (raddr
// must match the outstanding line); writes stream the latched line out one
// beat per accepted cycle. Any return beat that cannot belong to the
// outstanding read is dropped and raises a sticky error flag.

module bmem_line_adapter #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       dfp_addr,
  input  logic              dfp_read,
  input  logic              dfp_write,
  input  logic [LINE_W-1:0] dfp_wdata,
  output logic [LINE_W-1:0] dfp_rdata,
  output logic              dfp_resp,
  output logic [31:0]       bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic [31:0]       bmem_raddr,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid,
  output logic              err
);

  localparam int NBEAT = LINE_W / BEAT_W;
  localparam int CNT_W = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEAT - 1);
  // Clears the byte-within-line offset so the latched address is line aligned.
  localparam logic [31:0] LINE_MASK = ~(32'(LINE_W / 8) - 32'd1);

  // Line buffer viewed as beats so the beat counter indexes it directly.
  typedef logic [NBEAT-1:0][BEAT_W-1:0] line_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_REQ   = 3'd1,
    ST_RD_WAIT  = 3'd2,
    ST_WR_BURST = 3'd3,
    ST_RESP     = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  line_t            line_q, line_d;
  logic             err_q, err_d;

  logic             beat_hit_s;
  logic             stray_beat_s;

  // Classify a return beat: accepted only while waiting on the matching line.
  always_comb begin
    beat_hit_s   = bmem_rvalid && (state_q == ST_RD_WAIT) && (bmem_raddr == addr_q);
    stray_beat_s = bmem_rvalid && !beat_hit_s;
  end

  // State register; reset abandons any burst in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; requests are only looked at in IDLE, read has priority.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (dfp_read) begin
          state_d = ST_RD_REQ;
        end else if (dfp_write) begin
          state_d = ST_WR_BURST;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_REQ: begin
        if (bmem_ready) begin
          state_d = ST_RD_WAIT;
        end else begin
          state_d = ST_RD_REQ;
        end
      end
      ST_RD_WAIT: begin
        if (beat_hit_s && (cnt_q == LAST_BEAT)) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_RD_WAIT;
        end
      end
      ST_WR_BURST: begin
        if (bmem_ready && (cnt_q == LAST_BEAT)) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_WR_BURST;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath registers: beat counter, line address, line buffer, error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      addr_q <= 32'd0;
      line_q <= '0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
      line_q <= line_d;
      err_q  <= err_d;
    end
  end

  // Datapath next values: latch the request, fill or drain the line by beat.
  always_comb begin
    cnt_d  = cnt_q;
    addr_d = addr_q;
    line_d = line_q;
    err_d  = err_q | stray_beat_s;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (dfp_read) begin
          addr_d = dfp_addr & LINE_MASK;
        end else if (dfp_write) begin
          addr_d = dfp_addr & LINE_MASK;
          line_d = line_t'(dfp_wdata);
        end else begin
          addr_d = addr_q;
        end
      end
      ST_RD_WAIT: begin
        // Counter wraps to zero only on the final beat, as the FSM leaves.
        if (beat_hit_s) begin
          line_d[cnt_q] = bmem_rdata;
          cnt_d         = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_WR_BURST: begin
        if (bmem_ready) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_RD_REQ, ST_RESP: begin
        cnt_d = cnt_q;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // Output decode from the state register; request lines are mutually exclusive.
  always_comb begin
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_addr  = 32'd0;
    bmem_wdata = '0;
    dfp_resp   = 1'b0;
    dfp_rdata  = LINE_W'(line_q);
    err        = err_q;
    case (state_q)
      ST_RD_REQ: begin
        bmem_read = 1'b1;
        bmem_addr = addr_q;
      end
      ST_WR_BURST: begin
        bmem_write = 1'b1;
        bmem_addr  = addr_q;
        bmem_wdata = line_q[cnt_q];
      end
      ST_RESP: begin
        dfp_resp = 1'b1;
      end
      default: begin
        dfp_resp = 1'b0;
      end
    endcase
  end

endmodule
